// File: rtl/synt_cal_seq.sv
// Power-up and calibration sequencer for the RX frequency synthesizer.
// Settles the VCO, runs an MSB-first SAR search on the VCO cap bank, enables
// the PLL and qualifies lock before raising ready. All outputs are registered.
module synt_cal_seq #(
    parameter int CAP_W        = 6,
    parameter int SETTLE_CYC   = 16,
    parameter int CMP_WAIT     = 4,
    parameter int LOCK_CNT     = 32,
    parameter int UNLOCK_CNT   = 4,
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pu_synt,
    input  logic             cal_synt,
    input  logic             vco_fast,
    input  logic             lock_det,
    output logic             vco_en,
    output logic             pll_en,
    output logic [CAP_W-1:0] cap_code,
    output logic             cal_busy,
    output logic             rdy_synt,
    output logic             cal_err
);

    // One cycle counter serves both the settle window and the per-bit SAR wait.
    localparam int CYC_MAX = (SETTLE_CYC > CMP_WAIT) ? SETTLE_CYC : CMP_WAIT;
    localparam int CYC_W   = $clog2(CYC_MAX + 1);
    localparam int LCK_W   = $clog2(LOCK_CNT + 1);
    localparam int ULK_W   = $clog2(UNLOCK_CNT + 1);
    localparam int TMO_W   = $clog2(LOCK_TIMEOUT + 1);

    localparam logic [CYC_W-1:0] SETTLE_LAST = CYC_W'(SETTLE_CYC - 1);
    localparam logic [CYC_W-1:0] CMP_LAST    = CYC_W'(CMP_WAIT - 1);
    localparam logic [LCK_W-1:0] LOCK_FULL   = LCK_W'(LOCK_CNT);
    localparam logic [ULK_W-1:0] UNLOCK_LAST = ULK_W'(UNLOCK_CNT - 1);
    localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(LOCK_TIMEOUT - 1);
    localparam logic [CAP_W-1:0] MSB_BIT     = {1'b1, {(CAP_W-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        SAR,
        LOCKWAIT,
        READY,
        FAIL
    } state_t;

    state_t             state, state_d;
    logic [CYC_W-1:0]   cyc_cnt, cyc_d;
    logic [CAP_W-1:0]   mask, mask_d;       // one-hot bit currently under trial
    logic [CAP_W-1:0]   trial, trial_d;
    logic [CAP_W-1:0]   code_q, code_q_d;   // last completed calibration
    logic [LCK_W-1:0]   lock_cnt, lock_d;
    logic [ULK_W-1:0]   unlock_cnt, unlock_d;
    logic [TMO_W-1:0]   tmo_cnt, tmo_d;
    logic               vco_en_d, pll_en_d, cal_busy_d, rdy_d, err_d;
    logic [CAP_W-1:0]   cap_code_d;

    // Next-state, counter and output decode for the sequencer.
    always_comb begin
        // NOTE: every value written here gets a default first, so no latch is inferred.
        state_d  = state;
        cyc_d    = cyc_cnt;
        mask_d   = mask;
        trial_d  = trial;
        code_q_d = code_q;
        lock_d   = lock_cnt;
        unlock_d = unlock_cnt;
        tmo_d    = tmo_cnt;

        case (state)
            IDLE: begin
                if (pu_synt) begin
                    state_d = SETTLE;
                    cyc_d   = '0;
                end
            end
            SETTLE: begin
                if (cyc_cnt == SETTLE_LAST) begin
                    cyc_d = '0;
                    // The calibrate request only matters on this one cycle.
                    if (cal_synt) begin
                        state_d = SAR;
                        mask_d  = MSB_BIT;
                        trial_d = MSB_BIT;
                    end else begin
                        state_d = LOCKWAIT;
                        lock_d  = '0;
                        tmo_d   = '0;
                    end
                end else begin
                    cyc_d = cyc_cnt + 1'b1;
                end
            end
            SAR: begin
                if (cyc_cnt == CMP_LAST) begin
                    cyc_d = '0;
                    // VCO too slow at this code: drop the cap bit under trial.
                    if (!vco_fast) begin
                        trial_d = trial & ~mask;
                    end
                    if (mask[0]) begin
                        code_q_d = trial_d;
                        state_d  = LOCKWAIT;
                        lock_d   = '0;
                        tmo_d    = '0;
                    end else begin
                        mask_d  = mask >> 1;
                        trial_d = trial_d | (mask >> 1);
                    end
                end else begin
                    cyc_d = cyc_cnt + 1'b1;
                end
            end
            LOCKWAIT: begin
                // Lock is tested first so it wins a tie with the timeout.
                if (lock_cnt == LOCK_FULL) begin
                    state_d  = READY;
                    unlock_d = '0;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_d = FAIL;
                end else begin
                    tmo_d  = tmo_cnt + 1'b1;
                    lock_d = lock_det ? lock_cnt + 1'b1 : '0;
                end
            end
            READY: begin
                if (!lock_det) begin
                    if (unlock_cnt == UNLOCK_LAST) begin
                        state_d  = LOCKWAIT;
                        lock_d   = '0;
                        tmo_d    = '0;
                        unlock_d = '0;
                    end else begin
                        unlock_d = unlock_cnt + 1'b1;
                    end
                end else begin
                    unlock_d = '0;
                end
            end
            FAIL: begin
                state_d = FAIL;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Power-down overrides every other transition; an aborted SAR keeps the old code.
        if (!pu_synt) begin
            state_d  = IDLE;
            cyc_d    = '0;
            mask_d   = '0;
            trial_d  = code_q;
            code_q_d = code_q;
            lock_d   = '0;
            unlock_d = '0;
            tmo_d    = '0;
        end

        // Outputs are decoded from the next state and registered with it.
        vco_en_d   = (state_d != IDLE);
        pll_en_d   = (state_d == LOCKWAIT) || (state_d == READY);
        cal_busy_d = (state_d == SAR);
        rdy_d      = (state_d == READY);
        err_d      = (state_d == FAIL);
        cap_code_d = (state_d == SAR) ? trial_d : code_q_d;
    end

    // State, counters and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register updates from pre-edge values.
        if (rst) begin
            state      <= IDLE;
            cyc_cnt    <= '0;
            mask       <= '0;
            trial      <= '0;
            code_q     <= '0;
            lock_cnt   <= '0;
            unlock_cnt <= '0;
            tmo_cnt    <= '0;
            vco_en     <= 1'b0;
            pll_en     <= 1'b0;
            cap_code   <= '0;
            cal_busy   <= 1'b0;
            rdy_synt   <= 1'b0;
            cal_err    <= 1'b0;
        end else begin
            state      <= state_d;
            cyc_cnt    <= cyc_d;
            mask       <= mask_d;
            trial      <= trial_d;
            code_q     <= code_q_d;
            lock_cnt   <= lock_d;
            unlock_cnt <= unlock_d;
            tmo_cnt    <= tmo_d;
            vco_en     <= vco_en_d;
            pll_en     <= pll_en_d;
            cap_code   <= cap_code_d;
            cal_busy   <= cal_busy_d;
            rdy_synt   <= rdy_d;
            cal_err    <= err_d;
        end
    end

endmodule

// File: tb/tb_synt_cal_seq.sv
// Directed testbench for synt_cal_seq: calibration, fast power-up, unlock
// handling, lock timeout, SAR abort, reset in READY and SAR code extremes.
module tb_synt_cal_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       pu_synt;
    logic       cal_synt;
    logic       vco_fast;
    logic       lock_det;
    logic       vco_en;
    logic       pll_en;
    logic [5:0] cap_code;
    logic       cal_busy;
    logic       rdy_synt;
    logic       cal_err;

    logic [5:0] target;
    int         n_tests = 0;
    int         n_fail  = 0;

    // VCO model: running fast whenever the cap code is at or below the target.
    assign vco_fast = (cap_code <= target);

    always #5 clk = ~clk;

    synt_cal_seq dut (
        .clk      (clk),
        .rst      (rst),
        .pu_synt  (pu_synt),
        .cal_synt (cal_synt),
        .vco_fast (vco_fast),
        .lock_det (lock_det),
        .vco_en   (vco_en),
        .pll_en   (pll_en),
        .cap_code (cap_code),
        .cal_busy (cal_busy),
        .rdy_synt (rdy_synt),
        .cal_err  (cal_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Raise PU_SYNT and step until RDY_SYNT; edge 0 is the first edge seeing PU high.
    task automatic power_up(input logic cal, input int budget,
                            output int rdy_edge, output int busy_cycles);
        pu_synt     = 1'b1;
        cal_synt    = cal;
        rdy_edge    = -1;
        busy_cycles = 0;
        for (int e = 0; e < budget; e++) begin
            step();
            if (cal_busy) busy_cycles++;
            if (rdy_synt) begin
                rdy_edge = e;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; pu_synt = 1'b0; cal_synt = 1'b0; lock_det = 1'b1; target = 6'h2B;
        step(); step();
        rst = 1'b0;
        n_tests++;
        if ({vco_en, pll_en, cal_busy, rdy_synt, cal_err} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 00000", {vco_en, pll_en, cal_busy, rdy_synt, cal_err});
        end
        n_tests++;
        if (cap_code !== 6'h00) begin
            n_fail++;
            $display("FAIL reset_cap: got %h expected 00", cap_code);
        end
    endtask

    task automatic test_calibrate();
        int re, bc;
        target = 6'h2B; lock_det = 1'b1;
        power_up(1'b1, 200, re, bc);
        n_tests++;
        if (re !== 73) begin
            n_fail++;
            $display("FAIL cal_rdy_latency: got %0d expected 73", re);
        end
        n_tests++;
        if (bc !== 24) begin
            n_fail++;
            $display("FAIL cal_busy_cycles: got %0d expected 24", bc);
        end
        n_tests++;
        if (cap_code !== 6'h2B) begin
            n_fail++;
            $display("FAIL cal_code: got %h expected 2b", cap_code);
        end
        n_tests++;
        if ({vco_en, pll_en} !== 2'b11) begin
            n_fail++;
            $display("FAIL cal_ready_enables: got %b expected 11", {vco_en, pll_en});
        end
    endtask

    task automatic test_no_cal();
        int re, bc;
        pu_synt = 1'b0;
        step();
        n_tests++;
        if ({vco_en, pll_en, cal_busy, rdy_synt, cal_err} !== 5'b0) begin
            n_fail++;
            $display("FAIL idle_flags: got %b expected 00000", {vco_en, pll_en, cal_busy, rdy_synt, cal_err});
        end
        n_tests++;
        if (cap_code !== 6'h2B) begin
            n_fail++;
            $display("FAIL idle_cap: got %h expected 2b", cap_code);
        end
        target = 6'h05;  // a new SAR would land elsewhere, so code retention is visible
        power_up(1'b0, 200, re, bc);
        n_tests++;
        if (re !== 49) begin
            n_fail++;
            $display("FAIL nocal_rdy_latency: got %0d expected 49", re);
        end
        n_tests++;
        if (bc !== 0) begin
            n_fail++;
            $display("FAIL nocal_busy_cycles: got %0d expected 0", bc);
        end
        n_tests++;
        if (cap_code !== 6'h2B) begin
            n_fail++;
            $display("FAIL nocal_code: got %h expected 2b", cap_code);
        end
    endtask

    task automatic test_unlock();
        int rdy_at_32, rdy_at_33;
        lock_det = 1'b0;
        step(); step(); step();
        n_tests++;
        if (rdy_synt !== 1'b1) begin
            n_fail++;
            $display("FAIL glitch3_rdy: got %b expected 1", rdy_synt);
        end
        lock_det = 1'b1;
        step();
        lock_det = 1'b0;
        step(); step(); step();
        n_tests++;
        if (rdy_synt !== 1'b1) begin
            n_fail++;
            $display("FAIL unlock3_rdy: got %b expected 1", rdy_synt);
        end
        step();
        n_tests++;
        if ({rdy_synt, pll_en} !== 2'b01) begin
            n_fail++;
            $display("FAIL unlock4_rdy_pll: got %b expected 01", {rdy_synt, pll_en});
        end
        lock_det = 1'b1;
        rdy_at_32 = 0;
        rdy_at_33 = 0;
        for (int e = 1; e <= 33; e++) begin
            step();
            if (e == 32) rdy_at_32 = int'(rdy_synt);
            if (e == 33) rdy_at_33 = int'(rdy_synt);
        end
        n_tests++;
        if ({rdy_at_32[0], rdy_at_33[0]} !== 2'b01) begin
            n_fail++;
            $display("FAIL relock_timing: got %b expected 01", {rdy_at_32[0], rdy_at_33[0]});
        end
        n_tests++;
        if (cap_code !== 6'h2B) begin
            n_fail++;
            $display("FAIL relock_code: got %h expected 2b", cap_code);
        end
    endtask

    task automatic test_timeout();
        int fe;
        pu_synt = 1'b0;
        step();
        pu_synt = 1'b1; cal_synt = 1'b0;
        fe = -1;
        for (int e = 0; e < 1200; e++) begin
            lock_det = ((e / 10) % 2 == 0);
            step();
            if (rdy_synt) begin
                n_fail++;
                $display("FAIL timeout_spurious_rdy: got 1 expected 0 at edge %0d", e);
            end
            if (cal_err) begin
                fe = e;
                break;
            end
        end
        n_tests++;
        if (fe !== 1040) begin
            n_fail++;
            $display("FAIL timeout_edge: got %0d expected 1040", fe);
        end
        n_tests++;
        if ({vco_en, pll_en, rdy_synt, cal_err} !== 4'b1001) begin
            n_fail++;
            $display("FAIL fail_outputs: got %b expected 1001", {vco_en, pll_en, rdy_synt, cal_err});
        end
        lock_det = 1'b1;
        pu_synt  = 1'b0;
        step();
        n_tests++;
        if ({vco_en, pll_en, cal_busy, rdy_synt, cal_err} !== 5'b0) begin
            n_fail++;
            $display("FAIL fail_exit: got %b expected 00000", {vco_en, pll_en, cal_busy, rdy_synt, cal_err});
        end
    endtask

    task automatic test_sar_abort();
        int re, bc;
        target = 6'h10; lock_det = 1'b1;
        pu_synt = 1'b1; cal_synt = 1'b1;
        for (int e = 0; e <= 24; e++) step();
        // Edge k+24: bit 3 under trial; bit 5 cleared, bit 4 kept.
        n_tests++;
        if ({cal_busy, cap_code} !== {1'b1, 6'h18}) begin
            n_fail++;
            $display("FAIL sar_bit3_trial: got %b_%h expected 1_18", cal_busy, cap_code);
        end
        pu_synt = 1'b0;
        step();
        n_tests++;
        if ({vco_en, cal_busy, cap_code} !== {2'b00, 6'h2B}) begin
            n_fail++;
            $display("FAIL abort_outputs: got %b_%h expected 00_2b", {vco_en, cal_busy}, cap_code);
        end
        power_up(1'b0, 200, re, bc);
        n_tests++;
        if ({re[7:0], cap_code} !== {8'd49, 6'h2B}) begin
            n_fail++;
            $display("FAIL abort_code_kept: got %0d_%h expected 49_2b", re, cap_code);
        end
    endtask

    task automatic test_reset_extremes();
        int re, bc;
        rst = 1'b1;
        step();
        n_tests++;
        if ({vco_en, pll_en, cal_busy, rdy_synt, cal_err, cap_code} !== 11'b0) begin
            n_fail++;
            $display("FAIL rst_in_ready: got %b_%h expected 00000_00",
                     {vco_en, pll_en, cal_busy, rdy_synt, cal_err}, cap_code);
        end
        pu_synt = 1'b0;
        step();
        rst = 1'b0;
        target = 6'h00;
        power_up(1'b1, 200, re, bc);
        n_tests++;
        if ({re[7:0], cap_code} !== {8'd73, 6'h00}) begin
            n_fail++;
            $display("FAIL extreme_zero: got %0d_%h expected 73_00", re, cap_code);
        end
        pu_synt = 1'b0;
        step();
        target = 6'h3F;
        power_up(1'b1, 200, re, bc);
        n_tests++;
        if ({re[7:0], cap_code} !== {8'd73, 6'h3F}) begin
            n_fail++;
            $display("FAIL extreme_max: got %0d_%h expected 73_3f", re, cap_code);
        end
    endtask

    initial begin
        test_reset();
        test_calibrate();
        test_no_cal();
        test_unlock();
        test_timeout();
        test_sar_abort();
        test_reset_extremes();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
